tap_tempo: RTL and testbench
============================

TAP_TEMPO -- requirements
Module: tap_tempo

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, Clock frequency in Hz.
REQ-002 SHALL have parameter DEBOUNCE, default 500_000, cycles a changed Tap level must be stable before it is accepted.
REQ-003 SHALL have parameter TIMEOUT, default 150_000_000, cycles without a tap event before tempo capture is abandoned.
REQ-004 SHALL use one clock and a synchronous, active-high reset: Clock  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port Reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port Tap  input  1  raw asynchronous tap button, active-high.
REQ-007 SHALL have port BPM  output  9  last measured tempo, beats per minute, 0..511.
REQ-008 SHALL have port Valid  output  1  one-cycle pulse when BPM has just been updated.
REQ-009 SHALL have port Busy  output  1  high while the divider runs.
REQ-010 SHALL have port Active  output  1  high when state is not IDLE.

Function
REQ-011 SHALL pass Tap through a two-flop synchronizer before any other use.
REQ-012 SHALL update the debounced level only after the synced value differs from it for DEBOUNCE consecutive cycles; any shorter excursion resets the stability count.
REQ-013 SHALL define a tap event as the single cycle in which the debounced level rises 0->1.
REQ-014 SHALL implement states IDLE, ARMED, DIVIDE; reset state IDLE.
REQ-015 SHALL, in IDLE on a tap event, clear interval counter Q to 0, clear the history (count=0), and go to ARMED; no Valid.
REQ-016 SHALL increment 32-bit Q every cycle in ARMED and DIVIDE, so Q at a tap event equals the cycles since the previous tap event.
REQ-017 SHALL, in ARMED when Q reaches TIMEOUT with no tap event, go to IDLE, clear the history, and hold BPM.
REQ-018 SHALL, in ARMED on a tap event, shift Q into a 4-entry interval history, set count=min(count+1,4), clear Q, and go to DIVIDE; a tap event in the same cycle as the timeout takes priority over it.
REQ-019 SHALL compute quotient = (CLK_HZ*60*count) / (sum of the newest count history entries), unsigned, truncated, using a sequential restoring divider with a 36-bit numerator, a 32-bit divisor, and 1 bit per cycle.
REQ-020 SHALL keep DIVIDE for exactly 36 cycles, starting the cycle after the tap event; Busy is high exactly in those cycles.
REQ-021 SHALL, in the cycle after DIVIDE ends (tap event cycle + 37), load BPM with min(quotient,511), pulse Valid for one cycle, and return to ARMED.
REQ-022 SHALL ignore tap events during DIVIDE, with no history change and no Q clear.
REQ-023 SHALL hold BPM between updates; Valid is never high for two consecutive cycles.
REQ-024 SHALL never divide by zero: a zero interval sum yields BPM=511.

Reset
REQ-025 SHALL, on Reset, force BPM=0, Valid=0, Busy=0, Active=0, state=IDLE, Q=0, count=0, history=0, synchronizer and debounced level=0, and abort any divide in progress with no Valid.
REQ-026 SHALL release into normal operation on the first cycle after Reset deasserts; Tap held high through reset produces no tap event until it falls and rises again.

Verification (CLK_HZ=1000, DEBOUNCE=4, TIMEOUT=3000)
REQ-027 SHALL cover: Reset asserted 5 cycles -> BPM=0, Valid=0, Busy=0, Active=0.
REQ-028 SHALL cover: two tap events 500 cycles apart -> Valid once at the second event +37 cycles, BPM=120; a third event 600 cycles later -> BPM=120000/1100=109.
REQ-029 SHALL cover: intervals 500,500,500,500,250 -> final BPM=240000/1750=137, with the oldest interval dropped.
REQ-030 SHALL cover: interval 100 cycles -> quotient 600 clamped to BPM=511.
REQ-031 SHALL cover: no tap for 3000 cycles after ARMED -> Active=0 and BPM held; the next tap gives no Valid; a tap 500 cycles later -> BPM=120 (count=1).
REQ-032 SHALL cover: a 3-cycle Tap glitch -> no tap event; Reset asserted mid-DIVIDE -> Valid never pulses and BPM=0.

Source files
------------

// File: rtl/tap_tempo.sv
// Tap-tempo meter. The raw Tap button is synchronized and debounced, and each
// rising debounced edge counts as one tap event. The cycles between events
// are kept in a four-entry history. After every tap, a restoring divider
// turns the newest intervals into beats per minute.
module tap_tempo #(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned DEBOUNCE = 500_000,
  parameter int unsigned TIMEOUT  = 150_000_000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Tap,
  output logic [8:0] BPM,
  output logic       Valid,
  output logic       Busy,
  output logic       Active
);

  typedef enum logic [1:0] {IDLE, ARMED, DIVIDE} state_t;

  // Cycles per minute; the numerator is this value times the interval count.
  localparam logic [35:0] NUM_UNIT = 36'(64'(CLK_HZ) * 64'd60);

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]  start_q, start_d;
  logic        seen_low_q, seen_low_d;
  logic        deb_q, deb_d;
  logic [31:0] db_cnt_q, db_cnt_d;
  logic        tap_evt;
  logic [31:0] q_q, q_d;
  logic [31:0] hist_q [4];
  logic [31:0] hist_d [4];
  logic [31:0] shift_h [4];
  logic [2:0]  cnt_q, cnt_d, cnt_new;
  logic [33:0] sum_w;
  logic [35:0] num_q, num_d, num_nx;
  logic [32:0] rem_q, rem_d, rem_sh, rem_nx;
  logic [31:0] den_q, den_d;
  logic [5:0]  step_q, step_d;
  logic [8:0]  bpm_q, bpm_d;
  logic        valid_q, valid_d, busy_q, busy_d, active_q, active_d;

  function automatic logic [8:0] sat_bpm(input logic [35:0] v);
    return (v > 36'd511) ? 9'd511 : v[8:0];
  endfunction

  assign BPM    = bpm_q;
  assign Valid  = valid_q;
  assign Busy   = busy_q;
  assign Active = active_q;

  // Next-state logic: synchronizer, debouncer, tap FSM and one divider step
  always_comb begin
    sync1_d    = Tap;
    sync2_d    = sync1_q;
    // The synchronizer output is only real two cycles after reset. A tap
    // must see a low level first, so a button held through reset is ignored.
    start_d    = (start_q == 2'd2) ? start_q : start_q + 2'd1;
    seen_low_d = seen_low_q | ((start_q == 2'd2) & ~sync2_q);

    deb_d    = deb_q;
    db_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (db_cnt_q == 32'(DEBOUNCE - 1)) begin
        deb_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 32'd1;
      end
    end
    tap_evt = deb_d & ~deb_q & seen_low_q;

    // Candidate history: the newest interval goes into slot 0.
    shift_h[0] = q_q + 32'd1;
    for (int i = 1; i < 4; i++) shift_h[i] = hist_q[i-1];
    cnt_new = (cnt_q == 3'd4) ? 3'd4 : cnt_q + 3'd1;
    sum_w   = '0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < cnt_new) sum_w = sum_w + {2'b00, shift_h[i]};
    end

    // One restoring step: the quotient bits shift into num from the right.
    rem_sh = {rem_q[31:0], num_q[35]};
    if (rem_sh >= {1'b0, den_q}) begin
      rem_nx = rem_sh - {1'b0, den_q};
      num_nx = {num_q[34:0], 1'b1};
    end else begin
      rem_nx = rem_sh;
      num_nx = {num_q[34:0], 1'b0};
    end

    state_d = state_q;
    q_d     = q_q;
    hist_d  = hist_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    rem_d   = rem_q;
    den_d   = den_q;
    step_d  = step_q;
    bpm_d   = bpm_q;
    valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (tap_evt) begin
          q_d     = '0;
          cnt_d   = '0;
          hist_d  = '{default: '0};
          state_d = ARMED;
        end
      end
      ARMED: begin
        q_d = q_q + 32'd1;
        if (tap_evt) begin
          hist_d  = shift_h;
          cnt_d   = cnt_new;
          q_d     = '0;
          num_d   = NUM_UNIT * 36'(cnt_new);
          den_d   = sum_w[31:0];
          rem_d   = '0;
          step_d  = '0;
          state_d = DIVIDE;
        end else if (q_q >= 32'(TIMEOUT)) begin
          cnt_d   = '0;
          hist_d  = '{default: '0};
          state_d = IDLE;
        end
      end
      DIVIDE: begin
        q_d    = q_q + 32'd1;
        num_d  = num_nx;
        rem_d  = rem_nx;
        step_d = step_q + 6'd1;
        if (step_q == 6'd35) begin
          bpm_d   = (den_q == '0) ? 9'd511 : sat_bpm(num_nx);
          valid_d = 1'b1;
          state_d = ARMED;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d   = (state_d == DIVIDE);
    active_d = (state_d != IDLE);
  end

  // Control, history and output registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      start_q    <= '0;
      seen_low_q <= 1'b0;
      deb_q      <= 1'b0;
      db_cnt_q   <= '0;
      q_q        <= '0;
      hist_q     <= '{default: '0};
      cnt_q      <= '0;
      step_q     <= '0;
      bpm_q      <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      start_q    <= start_d;
      seen_low_q <= seen_low_d;
      deb_q      <= deb_d;
      db_cnt_q   <= db_cnt_d;
      q_q        <= q_d;
      hist_q     <= hist_d;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      bpm_q      <= bpm_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      active_q   <= active_d;
    end
  end

  // Divider datapath; it is always reloaded before use, so it needs no reset
  always_ff @(posedge Clock) begin
    num_q <= num_d;
    rem_q <= rem_d;
    den_q <= den_d;
  end

endmodule

// File: tb/tb_tap_tempo.sv
// Directed bench for tap_tempo with CLK_HZ=1000, DEBOUNCE=4 and TIMEOUT=3000.
// A Tap rise that is driven at cycle R gives a tap event at R+5. That makes
// Busy high for cycles R+6..R+41 and Valid high at cycle R+42.
module tb_tap_tempo;

  logic       clk = 1'b0;
  logic       rst;
  logic       tap;
  logic [8:0] bpm;
  logic       valid, busy, active;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int valid_cnt = 0, last_valid_cyc = -1, dbl_cnt = 0;
  int busy_cycles = 0, busy_first = -1, busy_last = -1;
  logic prev_valid = 1'b0, prev_busy = 1'b0;
  int r, v0, b0;

  tap_tempo #(.CLK_HZ(1000), .DEBOUNCE(4), .TIMEOUT(3000)) dut (
    .Clock(clk), .Reset(rst), .Tap(tap),
    .BPM(bpm), .Valid(valid), .Busy(busy), .Active(active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Track Valid and Busy pulses away from the active edge
  always @(negedge clk) begin
    if (valid) begin
      valid_cnt      <= valid_cnt + 1;
      last_valid_cyc <= cyc;
      if (prev_valid) dbl_cnt <= dbl_cnt + 1;
    end
    if (busy) begin
      busy_cycles <= busy_cycles + 1;
      busy_last   <= cyc;
      if (!prev_busy) busy_first <= cyc;
    end
    prev_valid <= valid;
    prev_busy  <= busy;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int at);
    while (cyc < at) @(negedge clk);
  endtask

  task automatic press(input int at);
    wait_cyc(at);
    tap = 1'b1;
    repeat (8) @(negedge clk);
    tap = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    tap = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_bpm", int'(bpm), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_active", int'(active), 0);
    rst = 1'b0;

    // Two taps 500 apart, then a third 600 later
    r = cyc + 20;
    press(r);
    wait_cyc(r + 100);
    chk("armed_active", int'(active), 1);
    chk("first_tap_no_valid", valid_cnt, 0);
    r = r + 500;
    press(r);
    wait_cyc(r + 60);
    chk("t2_valid_cnt", valid_cnt, 1);
    chk("t2_valid_cyc", last_valid_cyc, r + 42);
    chk("t2_busy_first", busy_first, r + 6);
    chk("t2_busy_last", busy_last, r + 41);
    chk("t2_bpm", int'(bpm), 120);
    r = r + 600;
    press(r);
    wait_cyc(r + 60);
    chk("t3_bpm", int'(bpm), 109);
    chk("t3_valid_cnt", valid_cnt, 2);

    // Five intervals; the oldest 500 drops out of the window
    do_reset(3);
    v0 = valid_cnt;
    r = cyc + 20;
    press(r);
    press(r + 500);
    press(r + 1000);
    press(r + 1500);
    press(r + 2000);
    wait_cyc(r + 2060);
    chk("w4_bpm", int'(bpm), 120);
    r = r + 2250;
    press(r);
    wait_cyc(r + 60);
    chk("w5_bpm", int'(bpm), 137);
    chk("w5_valid_cnt", valid_cnt - v0, 5);

    // Timeout back to IDLE, then restart with count=1
    wait_cyc(r + 2900);
    chk("pre_timeout_active", int'(active), 1);
    wait_cyc(r + 3100);
    chk("timeout_active", int'(active), 0);
    chk("timeout_bpm_hold", int'(bpm), 137);
    v0 = valid_cnt;
    r = r + 3200;
    press(r);
    wait_cyc(r + 100);
    chk("rearm_no_valid", valid_cnt - v0, 0);
    chk("rearm_active", int'(active), 1);
    r = r + 500;
    press(r);
    wait_cyc(r + 60);
    chk("rearm_bpm", int'(bpm), 120);

    // Interval of 100 cycles: 600 BPM clamps to 511
    do_reset(3);
    r = cyc + 20;
    press(r);
    press(r + 100);
    wait_cyc(r + 160);
    chk("clamp_bpm", int'(bpm), 511);

    // A 3-cycle glitch is shorter than the debounce window
    v0 = valid_cnt;
    b0 = busy_cycles;
    tap = 1'b1;
    repeat (3) @(negedge clk);
    tap = 1'b0;
    repeat (100) @(negedge clk);
    chk("glitch_no_busy", busy_cycles - b0, 0);
    chk("glitch_no_valid", valid_cnt - v0, 0);
    chk("glitch_bpm_hold", int'(bpm), 511);

    // Reset during the divide aborts it without a Valid pulse
    v0 = valid_cnt;
    r = cyc + 10;
    press(r);
    wait_cyc(r + 20);
    chk("mid_div_busy", int'(busy), 1);
    do_reset(2);
    wait_cyc(r + 100);
    chk("abort_no_valid", valid_cnt - v0, 0);
    chk("abort_bpm", int'(bpm), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_active", int'(active), 0);

    // Tap held high through reset gives no event until it is pressed again
    tap = 1'b1;
    do_reset(3);
    repeat (50) @(negedge clk);
    chk("held_tap_no_event", int'(active), 0);
    tap = 1'b0;
    repeat (20) @(negedge clk);
    press(cyc);
    repeat (20) @(negedge clk);
    chk("held_tap_repress", int'(active), 1);

    chk("valid_never_double", dbl_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
